// File: rtl/approx_rc_serial_ctrl.sv
// Bit-serial approximate ripple-carry adder: one shared adder cell, one bit position per clock.
// Define APPROX_RC_ERR_EN to add a parallel exact chain that reports err_abs / err_max.
module approx_rc_serial_ctrl #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             exact_mode,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             ready,
    output logic             done,
    output logic [WIDTH:0]   out,
    output logic [WIDTH:0]   err_abs,
    output logic [WIDTH:0]   err_max
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [WIDTH:0]     out_q, out_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               em_q, em_d;
    logic               carry_q, carry_d;

    logic [WIDTH-1:0]   approx_mask;
    logic               use_approx, s_bit, c_bit, last_bit;
    logic [WIDTH:0]     final_sum;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign approx_mask[gi] = (gi < APPROX_BITS);
        end
    endgenerate

    // Operands are shifted right each RUN cycle, so bit 0 is always the current position.
    assign use_approx = approx_mask[idx_q] & ~em_q;
    assign s_bit      = use_approx ? (b_q[0] & carry_q) : (a_q[0] ^ b_q[0] ^ carry_q);
    assign c_bit      = use_approx ? ~carry_q
                                   : ((a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q));
    assign last_bit   = (state_q == RUN) && (idx_q == LAST_IDX);
    assign final_sum  = {c_bit, s_bit, sum_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            out_q   <= '0;
            idx_q   <= '0;
            em_q    <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            em_q    <= em_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        out_d   = out_q;
        idx_d   = idx_q;
        em_d    = em_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = in1;
                    b_d     = in2;
                    em_d    = exact_mode;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = c_bit;
                sum_d   = {s_bit, sum_q[WIDTH-1:1]};
                idx_d   = idx_q + 1'b1;
                if (last_bit) begin
                    out_d   = final_sum;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign out   = out_q;

`ifdef APPROX_RC_ERR_EN
    logic             ec_q, ec_d;
    logic [WIDTH-1:0] es_q, es_d;
    logic [WIDTH:0]   err_abs_q, err_abs_d, err_max_q, err_max_d;
    logic             xs_bit, xc_bit;
    logic [WIDTH:0]   exact_sum, diff;

    // Reference chain sees the same operand bits but always uses the exact cell.
    assign xs_bit    = a_q[0] ^ b_q[0] ^ ec_q;
    assign xc_bit    = (a_q[0] & b_q[0]) | (a_q[0] & ec_q) | (b_q[0] & ec_q);
    assign exact_sum = {xc_bit, xs_bit, es_q[WIDTH-1:1]};
    assign diff      = (exact_sum >= final_sum) ? (exact_sum - final_sum) : (final_sum - exact_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            ec_q      <= 1'b0;
            es_q      <= '0;
            err_abs_q <= '0;
            err_max_q <= '0;
        end else begin
            ec_q      <= ec_d;
            es_q      <= es_d;
            err_abs_q <= err_abs_d;
            err_max_q <= err_max_d;
        end
    end

    always_comb begin
        ec_d      = ec_q;
        es_d      = es_q;
        err_abs_d = err_abs_q;
        err_max_d = err_max_q;
        if (state_q == IDLE && start) begin
            ec_d = 1'b0;
        end else if (state_q == RUN) begin
            ec_d = xc_bit;
            es_d = {xs_bit, es_q[WIDTH-1:1]};
            if (last_bit) begin
                err_abs_d = diff;
                err_max_d = (diff > err_max_q) ? diff : err_max_q;
            end
        end
    end

    assign err_abs = err_abs_q;
    assign err_max = err_max_q;
`else
    assign err_abs = '0;
    assign err_max = '0;
`endif

endmodule

// File: tb/tb_approx_rc_serial_ctrl.sv
// Directed bench for approx_rc_serial_ctrl (WIDTH=8, APPROX_BITS=7): vector table plus
// hand-written sequences for start spamming and mid-run reset.
module tb_approx_rc_serial_ctrl;
    localparam int WIDTH       = 8;
    localparam int APPROX_BITS = 7;
    localparam int NVEC        = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             exact_mode;
    logic [WIDTH-1:0] in1, in2;
    logic             ready, done;
    logic [WIDTH:0]   out, err_abs, err_max;

    approx_rc_serial_ctrl #(.WIDTH(WIDTH), .APPROX_BITS(APPROX_BITS)) dut (
        .clk(clk), .rst(rst), .start(start), .exact_mode(exact_mode),
        .in1(in1), .in2(in2), .ready(ready), .done(done),
        .out(out), .err_abs(err_abs), .err_max(err_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             em;
        logic [WIDTH:0]   exp_out;
        logic [WIDTH:0]   exp_err;
    } vec_t;

    vec_t vecs [NVEC];
    int   tests = 0;
    int   fails = 0;
    int   run_max = 0;
    bit   err_en;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Reference built directly from the per-bit cell definitions.
    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic em);
        logic [WIDTH:0] r;
        logic c, cn;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < APPROX_BITS && !em) begin
                r[i] = b[i] & c;
                cn   = ~c;
            end else begin
                r[i] = a[i] ^ b[i] ^ c;
                cn   = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
            end
            c = cn;
        end
        r[WIDTH] = c;
        return r;
    endfunction

    // Issues one operation and watches it until ready returns; optionally spams start.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic em, input bit spam,
                          input logic [WIDTH:0] exp_out, input logic [WIDTH:0] exp_err);
        int low_cnt, done_cnt, done_at, exp_err_i;
        logic [WIDTH:0] got_out, got_err, got_max;
        low_cnt = 0; done_cnt = 0; done_at = 0;
        got_out = '0; got_err = '0; got_max = '0;
        in1 = a; in2 = b; exact_mode = em; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (ready) break;
            low_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
                got_out = out; got_err = err_abs; got_max = err_max;
            end
            if (spam) begin
                start = 1'b1;
                in1 = WIDTH'($urandom); in2 = WIDTH'($urandom); exact_mode = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        exp_err_i = err_en ? int'(exp_err) : 0;
        if (exp_err_i > run_max) run_max = exp_err_i;
        $display("[TB] %s a=%02h b=%02h em=%0d out=%03h err=%0d max=%0d done_at=%0d low=%0d",
                 tag, a, b, em, got_out, got_err, got_max, done_at, low_cnt);
        check({tag, " out"}, int'(got_out), int'(exp_out));
        check({tag, " err_abs"}, int'(got_err), exp_err_i);
        check({tag, " err_max"}, int'(got_max), run_max);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " done_latency"}, done_at, 9);
        check({tag, " ready_low"}, low_cnt, 9);
        check({tag, " out_hold"}, int'(out), int'(exp_out));
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rem;
        logic [WIDTH:0]   rs, ex;
        int               done_seen;
`ifdef APPROX_RC_ERR_EN
        err_en = 1'b1;
`else
        err_en = 1'b0;
`endif
        vecs[0] = '{8'h00, 8'h00, 1'b0, 9'h080, 9'd128};
        vecs[1] = '{8'hFF, 8'hFF, 1'b0, 9'h1AA, 9'd84};
        vecs[2] = '{8'hFF, 8'h01, 1'b1, 9'h100, 9'd0};
        vecs[3] = '{8'h55, 8'hAA, 1'b0, 9'h12A, 9'd43};
        vecs[4] = '{8'h12, 8'h34, 1'b1, 9'h046, 9'd0};
        vecs[5] = '{8'h80, 8'h00, 1'b0, 9'h100, 9'd128};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 9'h080, 9'd0};

        rst = 1'b1; start = 1'b0; exact_mode = 1'b0; in1 = '0; in2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset ready", int'(ready), 1);
        check("reset done", int'(done), 0);
        check("reset out", int'(out), 0);
        check("reset err_abs", int'(err_abs), 0);
        check("reset err_max", int'(err_max), 0);

        for (int v = 0; v < NVEC; v++)
            run_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].em, 1'b0,
                   vecs[v].exp_out, vecs[v].exp_err);

        // start held high with changing operands through RUN and DONE
        rs = ref_sum(8'h3C, 8'h5A, 1'b0);
        ex = 9'(8'h3C) + 9'(8'h5A);
        run_op("spam", 8'h3C, 8'h5A, 1'b0, 1'b1, rs, (ex >= rs) ? ex - rs : rs - ex);

        // reset while RUN is at bit index 4
        in1 = 8'hFF; in2 = 8'hFF; exact_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] abort ready=%0d done=%0d out=%03h err_max=%0d", ready, done, out, err_max);
        check("abort ready", int'(ready), 1);
        check("abort done", int'(done), 0);
        check("abort out", int'(out), 0);
        check("abort err_max", int'(err_max), 0);
        run_max = 0;
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("abort no_done", done_seen, 0);

        for (int r = 0; r < 40; r++) begin
            ra  = WIDTH'($urandom);
            rb  = WIDTH'($urandom);
            rem = 1'($urandom);
            rs  = ref_sum(ra, rb, rem);
            ex  = 9'(ra) + 9'(rb);
            if (rem) check($sformatf("rand%0d exact", r), int'(rs), int'(ex));
            run_op($sformatf("rand%0d", r), ra, rb, rem, 1'b0, rs, (ex >= rs) ? ex - rs : rs - ex);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
